// File: rtl/sram_axi_pkg.sv
// Shared types and encodings for the AXI-to-SRAM slave: FSM states, burst and
// response codes, and the byte-strobe to bit-mask helper.
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

package sram_axi_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    R_DATA = 2'd1,
    W_DATA = 2'd2,
    B_RESP = 2'd3
  } sram_axi_state_e;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // WRAP and the reserved encoding run as INCR but are flagged to the master.
  function automatic logic [1:0] burst_resp(input logic [1:0] burst);
    return (burst == BURST_FIXED || burst == BURST_INCR) ? RESP_OKAY : RESP_SLVERR;
  endfunction

  function automatic logic [31:0] strb_to_bweb(input logic [3:0] strb);
    logic [31:0] bweb;
    bweb = '1;
    for (int i = 0; i < 4; i++) begin
      bweb[8*i +: 8] = {8{~strb[i]}};
    end
    return bweb;
  endfunction

endpackage

// File: rtl/sram_axi_addr_gen.sv
// Word-address and beat counter shared by read and write bursts; holds the
// burst type and length captured at the address handshake.
module sram_axi_addr_gen
  import sram_axi_pkg::*;
#(
  parameter int AW = 14,
  parameter int LW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [AW-1:0] load_addr,
  input  logic [1:0]    load_burst,
  input  logic [LW-1:0] load_len,
  input  logic          advance,
  output logic [AW-1:0] addr,
  output logic [AW-1:0] next_addr,
  output logic          at_last
);

  logic [1:0]    burst_q;
  logic [LW-1:0] len_q;
  logic [LW:0]   beat_q;

  // INCR wraps naturally at the top of the word space.
  assign next_addr = (burst_q == BURST_FIXED) ? addr : addr + 1'b1;
  assign at_last   = (beat_q == {1'b0, len_q});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr    <= '0;
      burst_q <= '0;
      len_q   <= '0;
      beat_q  <= '0;
    end else if (load) begin
      addr    <= load_addr;
      burst_q <= load_burst;
      len_q   <= load_len;
      beat_q  <= '0;
    end else if (advance) begin
      addr <= next_addr;
      // Saturate so an overlong write burst without WLAST cannot alias back to LEN.
      if (beat_q != '1) begin
        beat_q <= beat_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_axi_slave.sv
// Single-outstanding AXI slave in front of a 32-bit synchronous SRAM macro.
// Valid/ready: a transfer happens on a rising edge where both VALID and READY are 1.
module sram_axi_slave
  import sram_axi_pkg::*;
#(
  parameter int SRAM_AW = 14
) (
  input  logic                       ACLK,
  input  logic                       ARESETn,
  input  logic [`AXI_IDS_BITS-1:0]   AWID,
  input  logic [`AXI_ADDR_BITS-1:0]  AWADDR,
  input  logic [`AXI_LEN_BITS-1:0]   AWLEN,
  input  logic [`AXI_SIZE_BITS-1:0]  AWSIZE,
  input  logic [1:0]                 AWBURST,
  input  logic                       AWVALID,
  output logic                       AWREADY,
  input  logic [`AXI_DATA_BITS-1:0]  WDATA,
  input  logic [`AXI_STRB_BITS-1:0]  WSTRB,
  input  logic                       WLAST,
  input  logic                       WVALID,
  output logic                       WREADY,
  output logic [`AXI_IDS_BITS-1:0]   BID,
  output logic [1:0]                 BRESP,
  output logic                       BVALID,
  input  logic                       BREADY,
  input  logic [`AXI_IDS_BITS-1:0]   ARID,
  input  logic [`AXI_ADDR_BITS-1:0]  ARADDR,
  input  logic [`AXI_LEN_BITS-1:0]   ARLEN,
  input  logic [`AXI_SIZE_BITS-1:0]  ARSIZE,
  input  logic [1:0]                 ARBURST,
  input  logic                       ARVALID,
  output logic                       ARREADY,
  output logic [`AXI_IDS_BITS-1:0]   RID,
  output logic [`AXI_DATA_BITS-1:0]  RDATA,
  output logic [1:0]                 RRESP,
  output logic                       RLAST,
  output logic                       RVALID,
  input  logic                       RREADY,
  output logic                       SRAM_CEB,
  output logic                       SRAM_WEB,
  output logic [31:0]                SRAM_BWEB,
  output logic [SRAM_AW-1:0]         SRAM_A,
  output logic [31:0]                SRAM_DI,
  input  logic [31:0]                SRAM_DO,
  output sram_axi_state_e            dbg_state
);

  sram_axi_state_e          state_q;
  logic                     last_wr_q;
  logic [`AXI_IDS_BITS-1:0] id_q;
  logic [1:0]               resp_q;

  logic               grant_rd, grant_wr, in_idle;
  logic               ar_hs, aw_hs, r_hs, w_hs, b_hs;
  logic               rd_issue, wr_issue;
  logic [SRAM_AW-1:0] ar_word, aw_word, cur_addr, next_addr;
  logic               at_last;

  assign ar_word = ARADDR[SRAM_AW+1:2];
  assign aw_word = AWADDR[SRAM_AW+1:2];

  // On a tie the channel not served last wins; last_wr_q resets to 1 so read wins first.
  assign grant_rd = ARVALID && (!AWVALID || last_wr_q);
  assign grant_wr = AWVALID && !grant_rd;
  assign in_idle  = ARESETn && (state_q == IDLE);

  assign ARREADY = in_idle && grant_rd;
  assign AWREADY = in_idle && grant_wr;
  assign RVALID  = ARESETn && (state_q == R_DATA);
  assign WREADY  = ARESETn && (state_q == W_DATA);
  assign BVALID  = ARESETn && (state_q == B_RESP);

  assign ar_hs = ARVALID && ARREADY;
  assign aw_hs = AWVALID && AWREADY;
  assign r_hs  = RVALID && RREADY;
  assign w_hs  = WVALID && WREADY;
  assign b_hs  = BVALID && BREADY;

  assign RID   = id_q;
  assign RDATA = SRAM_DO;
  assign RRESP = resp_q;
  assign RLAST = (state_q == R_DATA) && at_last;
  assign BID   = id_q;
  assign BRESP = resp_q;

  // A read beat accepted mid-burst prefetches the next word so RDATA is ready next cycle.
  assign rd_issue = ar_hs || (r_hs && !at_last);
  assign wr_issue = w_hs;

  assign SRAM_CEB  = !(rd_issue || wr_issue);
  assign SRAM_WEB  = !wr_issue;
  assign SRAM_BWEB = wr_issue ? strb_to_bweb(WSTRB) : '1;
  assign SRAM_DI   = WDATA;
  assign SRAM_A    = ar_hs ? ar_word : ((state_q == R_DATA) ? next_addr : cur_addr);

  assign dbg_state = state_q;

  sram_axi_addr_gen #(
    .AW (SRAM_AW),
    .LW (`AXI_LEN_BITS)
  ) u_addr_gen (
    .clk        (ACLK),
    .rst_n      (ARESETn),
    .load       (ar_hs || aw_hs),
    .load_addr  (ar_hs ? ar_word : aw_word),
    .load_burst (ar_hs ? ARBURST : AWBURST),
    .load_len   (ar_hs ? ARLEN : AWLEN),
    .advance    ((r_hs && !at_last) || w_hs),
    .addr       (cur_addr),
    .next_addr  (next_addr),
    .at_last    (at_last)
  );

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q   <= IDLE;
      last_wr_q <= 1'b1;
      id_q      <= '0;
      resp_q    <= RESP_OKAY;
    end else begin
      case (state_q)
        IDLE: begin
          if (ar_hs) begin
            id_q      <= ARID;
            resp_q    <= burst_resp(ARBURST);
            last_wr_q <= 1'b0;
            state_q   <= R_DATA;
          end else if (aw_hs) begin
            id_q      <= AWID;
            resp_q    <= burst_resp(AWBURST);
            last_wr_q <= 1'b1;
            state_q   <= W_DATA;
          end
        end
        R_DATA: begin
          if (r_hs && at_last) begin
            state_q <= IDLE;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            // Early WLAST or a missing WLAST at LEN both poison the response.
            if (WLAST != at_last) begin
              resp_q <= RESP_SLVERR;
            end
            if (WLAST) begin
              state_q <= B_RESP;
            end
          end
        end
        B_RESP: begin
          if (b_hs) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{ARSIZE, AWSIZE, ARADDR[`AXI_ADDR_BITS-1:SRAM_AW+2], ARADDR[1:0],
                         AWADDR[`AXI_ADDR_BITS-1:SRAM_AW+2], AWADDR[1:0]};

endmodule

// File: tb/tb_sram_axi_slave.sv
// Directed bench for sram_axi_slave with a behavioural SRAM whose unwritten
// words read back as 0xC0DE0000 | word_address.
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

module tb_sram_axi_slave;
  import sram_axi_pkg::*;

  localparam int AW = 14;

  logic ACLK = 1'b0;
  logic ARESETn;
  always #5 ACLK = ~ACLK;

  logic [`AXI_IDS_BITS-1:0]  AWID, ARID, BID, RID;
  logic [`AXI_ADDR_BITS-1:0] AWADDR, ARADDR;
  logic [`AXI_LEN_BITS-1:0]  AWLEN, ARLEN;
  logic [`AXI_SIZE_BITS-1:0] AWSIZE, ARSIZE;
  logic [1:0]                AWBURST, ARBURST, BRESP, RRESP;
  logic                      AWVALID, AWREADY, WLAST, WVALID, WREADY;
  logic                      BVALID, BREADY, ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic [`AXI_DATA_BITS-1:0] WDATA, RDATA;
  logic [`AXI_STRB_BITS-1:0] WSTRB;
  logic                      SRAM_CEB, SRAM_WEB;
  logic [31:0]               SRAM_BWEB, SRAM_DI, SRAM_DO;
  logic [AW-1:0]             SRAM_A;
  sram_axi_state_e           dbg_state;

  sram_axi_slave #(.SRAM_AW(AW)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .SRAM_CEB(SRAM_CEB), .SRAM_WEB(SRAM_WEB), .SRAM_BWEB(SRAM_BWEB), .SRAM_A(SRAM_A),
    .SRAM_DI(SRAM_DI), .SRAM_DO(SRAM_DO), .dbg_state(dbg_state)
  );

  // Behavioural SRAM
  logic [31:0] mem     [0:(1<<AW)-1];
  bit          written [0:(1<<AW)-1];

  function automatic logic [31:0] pat(input int a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  function automatic logic [31:0] rd_word(input logic [AW-1:0] a);
    return written[a] ? mem[a] : pat(int'(a));
  endfunction

  always @(posedge ACLK) begin
    if (!SRAM_CEB) begin
      if (!SRAM_WEB) begin
        mem[SRAM_A]     <= (rd_word(SRAM_A) & SRAM_BWEB) | (SRAM_DI & ~SRAM_BWEB);
        written[SRAM_A] <= 1'b1;
      end else begin
        SRAM_DO <= rd_word(SRAM_A);
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge ACLK);
    #1;
  endtask

  task automatic smp();
    @(negedge ACLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESETn = 1'b0;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = 3'd2; AWBURST = BURST_INCR; AWVALID = 1'b1;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = 3'd2; ARBURST = BURST_INCR; ARVALID = 1'b1;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0; RREADY = 1'b0;

    // Reset with both address channels requesting
    next(); next(); smp();
    chk("rst_arready", ARREADY, 0);
    chk("rst_awready", AWREADY, 0);
    chk("rst_rvalid",  RVALID, 0);
    chk("rst_wready",  WREADY, 0);
    chk("rst_bvalid",  BVALID, 0);
    chk("rst_ceb",     SRAM_CEB, 1);
    chk("rst_web",     SRAM_WEB, 1);
    chk("rst_bweb",    SRAM_BWEB, 32'hFFFF_FFFF);

    // INCR read, ID 0x12, ADDR 0x100, LEN 3
    next();
    ARESETn = 1'b1; AWVALID = 1'b0;
    ARVALID = 1'b1; ARID = 8'h12; ARADDR = 32'h100; ARLEN = 4'd3; ARBURST = BURST_INCR;
    smp();
    chk("state_idle0", 32'(dbg_state), 32'(IDLE));
    chk("ar_ready",    ARREADY, 1);
    chk("ar_ceb",      SRAM_CEB, 0);
    chk("ar_web",      SRAM_WEB, 1);
    chk("ar_addr",     32'(SRAM_A), 32'h40);
    next();
    ARVALID = 1'b0; RREADY = 1'b1;
    for (int k = 0; k < 4; k++) begin
      smp();
      chk("rd_rvalid", RVALID, 1);
      chk("rd_rdata",  RDATA, pat(32'h40 + k));
      chk("rd_rid",    32'(RID), 32'h12);
      chk("rd_rresp",  32'(RRESP), 0);
      chk("rd_rlast",  32'(RLAST), 32'(k == 3));
      chk("rd_ceb",    SRAM_CEB, 32'(k == 3));
      if (k < 3) chk("rd_next_addr", 32'(SRAM_A), 32'h41 + k);
      next();
    end
    RREADY = 1'b0;
    smp();
    chk("rd_done_rvalid", RVALID, 0);
    chk("rd_done_state",  32'(dbg_state), 32'(IDLE));

    // Single-beat write with partial strobes, BREADY held off
    next();
    AWVALID = 1'b1; AWID = 8'h05; AWADDR = 32'h4; AWLEN = 4'd0; AWBURST = BURST_INCR;
    smp();
    chk("aw_ready",   AWREADY, 1);
    chk("aw_arready", ARREADY, 0);
    chk("aw_ceb",     SRAM_CEB, 1);
    next();
    AWVALID = 1'b0;
    WVALID = 1'b1; WDATA = 32'hAABB_CCDD; WSTRB = 4'b0101; WLAST = 1'b1;
    smp();
    chk("wr_wready", WREADY, 1);
    chk("wr_ceb",    SRAM_CEB, 0);
    chk("wr_web",    SRAM_WEB, 0);
    chk("wr_addr",   32'(SRAM_A), 32'h1);
    chk("wr_bweb",   SRAM_BWEB, 32'hFF00_FF00);
    chk("wr_di",     SRAM_DI, 32'hAABB_CCDD);
    next();
    WVALID = 1'b0; WLAST = 1'b0;
    for (int k = 0; k < 3; k++) begin
      smp();
      chk("b_hold_bvalid", BVALID, 1);
      chk("b_hold_bid",    32'(BID), 32'h05);
      chk("b_hold_bresp",  32'(BRESP), 0);
      chk("b_hold_ceb",    SRAM_CEB, 1);
      next();
    end
    BREADY = 1'b1;
    next();
    BREADY = 1'b0;
    smp();
    chk("b_done_bvalid", BVALID, 0);
    chk("b_done_state",  32'(dbg_state), 32'(IDLE));

    // LEN 1 with WLAST on the first beat
    next();
    AWVALID = 1'b1; AWID = 8'h07; AWADDR = 32'h20; AWLEN = 4'd1; AWBURST = BURST_INCR;
    next();
    AWVALID = 1'b0;
    WVALID = 1'b1; WDATA = 32'h1122_3344; WSTRB = 4'hF; WLAST = 1'b1;
    smp();
    chk("early_wr_ceb",  SRAM_CEB, 0);
    chk("early_wr_addr", 32'(SRAM_A), 32'h8);
    chk("early_wr_bweb", SRAM_BWEB, 32'h0);
    next();
    WVALID = 1'b0; WLAST = 1'b0;
    smp();
    chk("early_bvalid", BVALID, 1);
    chk("early_bresp",  32'(BRESP), 32'(RESP_SLVERR));
    chk("early_ceb",    SRAM_CEB, 1);
    BREADY = 1'b1;
    next();
    BREADY = 1'b0;

    // LEN 0 without WLAST on beat 0: writes continue to WLAST, response SLVERR
    AWVALID = 1'b1; AWID = 8'h08; AWADDR = 32'h30; AWLEN = 4'd0; AWBURST = BURST_INCR;
    next();
    AWVALID = 1'b0;
    WVALID = 1'b1; WDATA = 32'h0000_0001; WSTRB = 4'hF; WLAST = 1'b0;
    smp();
    chk("nolast_addr0", 32'(SRAM_A), 32'hC);
    next();
    WLAST = 1'b1; WDATA = 32'h0000_0002;
    smp();
    chk("nolast_wready", WREADY, 1);
    chk("nolast_addr1",  32'(SRAM_A), 32'hD);
    chk("nolast_web",    SRAM_WEB, 0);
    next();
    WVALID = 1'b0; WLAST = 1'b0;
    smp();
    chk("nolast_bresp", 32'(BRESP), 32'(RESP_SLVERR));
    BREADY = 1'b1;
    next();
    BREADY = 1'b0;

    // First simultaneous request: read wins, then write
    ARVALID = 1'b1; ARID = 8'h01; ARADDR = 32'h0; ARLEN = 4'd0; ARBURST = BURST_INCR;
    AWVALID = 1'b1; AWID = 8'h02; AWADDR = 32'h8; AWLEN = 4'd0; AWBURST = BURST_INCR;
    smp();
    chk("tie1_arready", ARREADY, 1);
    chk("tie1_awready", AWREADY, 0);
    next();
    ARVALID = 1'b0; RREADY = 1'b1;
    smp();
    chk("tie1_rid",     32'(RID), 32'h01);
    chk("tie1_rlast",   RLAST, 1);
    chk("tie1_rdata",   RDATA, pat(0));
    chk("tie1_aw_wait", AWREADY, 0);
    next();
    RREADY = 1'b0;
    smp();
    chk("tie1_awready2", AWREADY, 1);
    next();
    AWVALID = 1'b0;
    WVALID = 1'b1; WDATA = 32'h5566_7788; WSTRB = 4'hF; WLAST = 1'b1;
    smp();
    chk("tie1_wr_addr", 32'(SRAM_A), 32'h2);
    next();
    WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b1;
    smp();
    chk("tie1_bid", 32'(BID), 32'h02);
    next();
    BREADY = 1'b0;

    // FIXED read of LEN 2 at word 1 (partially written above)
    ARVALID = 1'b1; ARID = 8'h03; ARADDR = 32'h4; ARLEN = 4'd2; ARBURST = BURST_FIXED;
    smp();
    chk("fix_ar_addr", 32'(SRAM_A), 32'h1);
    next();
    ARVALID = 1'b0; RREADY = 1'b1;
    for (int k = 0; k < 3; k++) begin
      smp();
      chk("fix_rdata", RDATA, 32'hC0BB_00DD);
      chk("fix_rlast", 32'(RLAST), 32'(k == 2));
      chk("fix_rresp", 32'(RRESP), 0);
      if (k < 2) chk("fix_addr", 32'(SRAM_A), 32'h1);
      next();
    end
    RREADY = 1'b0;

    // Second simultaneous request after a read: write wins, then read
    ARVALID = 1'b1; ARID = 8'h09; ARADDR = 32'h10; ARLEN = 4'd0; ARBURST = BURST_INCR;
    AWVALID = 1'b1; AWID = 8'h0A; AWADDR = 32'hC; AWLEN = 4'd0; AWBURST = BURST_INCR;
    smp();
    chk("tie2_awready", AWREADY, 1);
    chk("tie2_arready", ARREADY, 0);
    next();
    AWVALID = 1'b0;
    WVALID = 1'b1; WDATA = 32'h9999_0000; WSTRB = 4'hF; WLAST = 1'b1;
    smp();
    chk("tie2_wr_addr", 32'(SRAM_A), 32'h3);
    chk("tie2_ar_wait", ARREADY, 0);
    next();
    WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b1;
    smp();
    chk("tie2_bid", 32'(BID), 32'h0A);
    next();
    BREADY = 1'b0;
    smp();
    chk("tie2_arready2", ARREADY, 1);
    chk("tie2_rd_addr",  32'(SRAM_A), 32'h4);
    next();
    ARVALID = 1'b0; RREADY = 1'b1;
    smp();
    chk("tie2_rid",   32'(RID), 32'h09);
    chk("tie2_rdata", RDATA, pat(4));
    next();
    RREADY = 1'b0;

    // WRAP read from the top word: runs as INCR, wraps to 0, SLVERR; stall holds data
    ARVALID = 1'b1; ARID = 8'h04; ARADDR = 32'hFFFC; ARLEN = 4'd3; ARBURST = BURST_WRAP;
    smp();
    chk("wrap_ar_addr", 32'(SRAM_A), 32'h3FFF);
    next();
    ARVALID = 1'b0;
    smp();
    chk("wrap_rdata0", RDATA, pat(32'h3FFF));
    chk("wrap_rresp",  32'(RRESP), 32'(RESP_SLVERR));
    chk("wrap_stall_ceb", SRAM_CEB, 1);
    next();
    smp();
    chk("wrap_stall_rdata", RDATA, pat(32'h3FFF));
    chk("wrap_stall_state", 32'(dbg_state), 32'(R_DATA));
    next();
    RREADY = 1'b1;
    smp();
    chk("wrap_ceb",   SRAM_CEB, 0);
    chk("wrap_addr",  32'(SRAM_A), 32'h0);
    chk("wrap_rlast", RLAST, 0);
    next();
    smp();
    chk("wrap_rdata1", RDATA, pat(0));

    // Reset mid-burst for one cycle
    next();
    ARESETn = 1'b0;
    smp();
    chk("mid_rst_rvalid", RVALID, 0);
    chk("mid_rst_ceb",    SRAM_CEB, 1);
    next();
    ARESETn = 1'b1; RREADY = 1'b0;
    smp();
    chk("post_rst_state",  32'(dbg_state), 32'(IDLE));
    chk("post_rst_rvalid", RVALID, 0);
    chk("post_rst_ceb",    SRAM_CEB, 1);

    // After reset the tie goes to read again; valids withdrawn before the edge
    next();
    ARVALID = 1'b1; AWVALID = 1'b1;
    smp();
    chk("post_rst_tie_ar", ARREADY, 1);
    chk("post_rst_tie_aw", AWREADY, 0);
    ARVALID = 1'b0; AWVALID = 1'b0;
    next();
    smp();
    chk("drop_state",  32'(dbg_state), 32'(IDLE));
    chk("drop_rvalid", RVALID, 0);
    chk("drop_wready", WREADY, 0);
    chk("drop_ceb",    SRAM_CEB, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_axi_slave.md
SRAM_AXI_SLAVE -- requirements
Module: sram_axi_slave

Interface
REQ-001 SHALL have parameter SRAM_AW, default 14, meaning SRAM word-address width (64 KB).
REQ-002 SHALL have port ACLK  in  1  sole clock; all logic on the rising edge.
REQ-003 SHALL have port ARESETn  in  1  reset, synchronous, active-low.
REQ-004 SHALL have AW ports AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  in, AWREADY  out, with widths `AXI_IDS_BITS/`AXI_ADDR_BITS/`AXI_LEN_BITS/`AXI_SIZE_BITS/2/1/1.
REQ-005 SHALL have W ports WDATA/WSTRB/WLAST/WVALID  in, WREADY  out, with widths `AXI_DATA_BITS/`AXI_STRB_BITS/1/1/1.
REQ-006 SHALL have B ports BID/BRESP/BVALID  out, BREADY  in, with widths `AXI_IDS_BITS/2/1/1.
REQ-007 SHALL have AR ports ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  in, ARREADY  out, mirroring the AW widths.
REQ-008 SHALL have R ports RID/RDATA/RRESP/RLAST/RVALID  out, RREADY  in, with widths `AXI_IDS_BITS/`AXI_DATA_BITS/2/1/1.
REQ-009 SHALL have SRAM ports SRAM_CEB out 1 (chip enable, active-low), SRAM_WEB out 1 (write enable, active-low), SRAM_BWEB out 32 (bit write mask, active-low), SRAM_A out SRAM_AW (word address), SRAM_DI out 32 (write data), SRAM_DO in 32 (read data: valid the cycle after a read, held until the next read).

Function
REQ-010 SHALL implement FSM states IDLE, R_DATA, W_DATA, B_RESP; one transaction at a time, no read/write overlap.
REQ-011 IDLE SHALL drive ARREADY/AWREADY combinationally from a grant: if only one of ARVALID/AWVALID is high, that channel is granted; if both are high, the channel not served last is granted; the last-served flag resets to "write", so read wins the first tie.
REQ-012 An AR handshake SHALL latch ID, LEN, BURST and word address ADDR[SRAM_AW+1:2], issue an SRAM read that same cycle (CEB=0, WEB=1, A=ARADDR word), and move to R_DATA.
REQ-013 R_DATA SHALL hold RVALID=1 with RDATA=SRAM_DO, RID=latched ID, RLAST=(beat count==LEN), and RRESP as set by REQ-017.
REQ-014 On an R handshake that is not last, the block SHALL issue the SRAM read of the next address in the same cycle, giving one beat per cycle under RREADY=1; without a handshake CEB SHALL stay 1 so SRAM_DO holds.
REQ-015 The last R handshake SHALL return the FSM to IDLE.
REQ-016 Address update per beat: INCR (01) adds 1 and wraps modulo 2^SRAM_AW; FIXED (00) holds the address.
REQ-017 WRAP (10) and reserved (11) bursts SHALL be executed as INCR with response SLVERR (2'b10); all other responses SHALL be OKAY (2'b00).
REQ-018 An AW handshake SHALL latch ID, LEN, BURST and word address, and move to W_DATA.
REQ-019 W_DATA SHALL hold WREADY=1, and each W handshake SHALL write the SRAM that cycle: CEB=0, WEB=0, DI=WDATA, BWEB[8i+7:8i]={8{~WSTRB[i]}}.
REQ-020 Each W handshake SHALL increment the beat count.
REQ-021 A W handshake with WLAST=1 SHALL move to B_RESP.
REQ-022 If WLAST arrives at a beat count other than LEN, or the count reaches LEN without WLAST, the response SHALL be SLVERR.
REQ-023 In the no-WLAST case, writes SHALL continue until WLAST; addresses advance per REQ-016.
REQ-024 B_RESP SHALL hold BVALID=1, BID=latched ID and the accumulated BRESP until BREADY, then return to IDLE.
REQ-025 Outside REQ-012/014/019, SRAM_CEB=1, SRAM_WEB=1 and SRAM_BWEB=all 1s.
REQ-026 A master's VALID dropping before handshake SHALL be tolerated with no state change.

Reset
REQ-027 While ARESETn=0 at a clock edge, state SHALL become IDLE and beat count and latched fields SHALL clear to 0.
REQ-028 During reset, all READY/VALID outputs SHALL be 0 and CEB/WEB/BWEB SHALL be all 1s.
REQ-029 Reset mid-burst SHALL abandon the burst with no further SRAM access; the last-served flag SHALL reset to "write".

Structure
REQ-030 Package sram_axi_pkg SHALL hold the FSM state enum, the burst encodings (FIXED/INCR/WRAP) and the response encodings (OKAY/SLVERR).
REQ-031 Sub-module sram_axi_addr_gen (address/beat counter, shared by read and write) SHALL be used; everything else is flat.

Verification
REQ-032 AR ID=0x12, ADDR=0x100, LEN=3, INCR with RREADY=1 -> SRAM reads at word addresses 0x40..0x43 on consecutive cycles; 4 R beats; RLAST on the 4th beat; RID=0x12; RRESP=0.
REQ-033 AW ADDR=0x4, LEN=0, WSTRB=4'b0101, WDATA=0xAABBCCDD -> one SRAM write at A=1 with BWEB=0xFF00FF00; then BVALID with BRESP=0; BREADY held low for 3 cycles -> BVALID stays high.
REQ-034 ARVALID and AWVALID rise together, twice -> read served first, then write; the second simultaneous request is served as write then read.
REQ-035 AW LEN=1, WLAST on the first beat -> one SRAM write, BRESP=2'b10; FIXED read LEN=2 -> all 3 reads to the same address.
REQ-036 INCR read at word 0x3FFF, LEN=1 -> second beat address 0x0000; ARESETn=0 mid-burst for one cycle -> IDLE next cycle, RVALID=0, CEB=1.
